alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-issue stage directly upstream of the ALU. It accepts decoded instruction fields from the decode/register-read logic over a valid/ready handshake and forms the final operands: immediate extension, shift-amount select and optional result forwarding. It buffers up to two entries in a skid buffer and presents the head entry to the ALU as `ALUInputA`, `ReadData2`, `ExtendOut`, `ALUSrcB` and `ALUOp`.

## Interface
- `DATA_W`, 32: operand width.
- `REG_AW`, 5: register address width.
- `CLK` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `InValid` in 1: upstream entry valid.
- `InReady` out 1: stage can accept an entry (`count < 2`).
- `ReadData1` in DATA_W: rs value from the register file.
- `ReadData2In` in DATA_W: rt value from the register file.
- `RsAddr` in REG_AW: rs index.
- `RtAddr` in REG_AW: rt index.
- `Sa` in 5: shift amount field.
- `Immediate` in 16: immediate field.
- `ExtSel` in 1: 1 = sign-extend the immediate, 0 = zero-extend.
- `ALUSrcA` in 1: 1 = operand A is `{27'b0,Sa}`, 0 = operand A is `ReadData1`.
- `ALUSrcBIn` in 1: passed through as `ALUSrcB`.
- `ALUOpIn` in 3: passed through as `ALUOp`.
- `FwdValid` in 1: a write-back is happening this cycle.
- `FwdAddr` in REG_AW: write-back destination.
- `FwdData` in DATA_W: write-back value.
- `Flush` in 1: synchronous discard of all entries.
- `OutValid` out 1: head entry valid.
- `OutReady` in 1: ALU consumer accepts the head entry.
- `ALUInputA` out DATA_W: operand A.
- `ReadData2` out DATA_W: rt operand.
- `ExtendOut` out DATA_W: extended immediate.
- `ALUSrcB` out 1: B-operand select, passed through.
- `ALUOp` out 3: ALU operation, passed through.

## Operation
- Storage is a 2-entry FIFO with head/tail pointers and a 2-bit `count`.
- An entry stores:
  - final A (after the ALUSrcA mux);
  - rt value;
  - ExtendOut;
  - ALUSrcB and ALUOp;
  - RsAddr and RtAddr;
  - an ALUSrcA flag.
- Push happens when `InValid && InReady`. Pop happens when `OutValid && OutReady`.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Extension is computed at push time:
  - `ExtSel=1`: `{{16{Immediate[15]}},Immediate}`.
  - `ExtSel=0`: `{16'b0,Immediate}`.
  - Example: `Immediate=16'h8001` gives `32'hFFFF8001` with ExtSel=1 and `32'h00008001` with ExtSel=0.
- Operand A at push time: `ALUSrcA ? {27'b0,Sa} : ReadData1`.
- Outputs are taken combinationally from the head entry. When `count==0`, all data outputs are 0 and `OutValid=0`.
- `Flush=1`: count and pointers go to 0 at the next edge.
  - Flush takes priority over push and pop in the same cycle.
  - An entry presented during a flush cycle is dropped.
- Reset: count, pointers and all entry fields go to 0. Resulting output values:
  - `OutValid=0`;
  - `InReady=1`;
  - all data outputs 0.

## Timing
- Latency: an entry pushed at edge N is visible on the outputs after edge N, provided the FIFO was empty.
- `InReady` depends only on count, with no combinational path from `OutReady`.
- Full (count=2) with `OutReady=1`: `InReady` stays 0 that cycle. The pop occurs, and the next cycle `InReady=1`.
- `OutValid` stays high and the head fields stay stable until `OutReady` is sampled high. No output field changes while `OutValid && !OutReady`, except through forwarding (see Configuration).
- Empty: `OutValid=0`. A pop request is ignored.
- Pointers wrap modulo 2.
- Reset asserted mid-transfer clears state immediately (asynchronously). Deassertion is synchronised externally.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding is enabled.
  - When `FwdValid && FwdAddr!=0`, the incoming entry at push takes `FwdData` in place of ReadData1 if `RsAddr==FwdAddr` (and ALUSrcA=0).
  - Likewise, it takes `FwdData` in place of ReadData2In if `RtAddr==FwdAddr`.
  - In the same cycle, every valid buffered entry with a matching RsAddr (and ALUSrcA flag 0) or RtAddr has that field overwritten at the edge.
- `ALU_ISSUE_FWD_EN` undefined:
  - `FwdValid`, `FwdAddr` and `FwdData` are ignored.
  - RsAddr/RtAddr storage is removed.

## Structure
- Package `cpu_pkg`:
  - `DATA_W` and `REG_AW` defaults;
  - ALUOp localparams: ADD 000, SUB 001, SLL 010, OR 011, AND 100, ANDN 101, XOR 110, XNOR 111;
  - the entry struct typedef.
- One combinational sub-module, `alu_operand_ext`: the immediate extension and the A-operand mux, instantiated once on the push path.

## Test plan
- Reset, then push ReadData1=5, ALUSrcA=0, ALUOpIn=000, OutReady=1 -> one cycle later OutValid=1, ALUInputA=5, ALUOp=000. Next cycle OutValid=0.
- Push Sa=4, ALUSrcA=1, Immediate=16'hFFFE, ExtSel=1 -> ALUInputA=4, ExtendOut=32'hFFFFFFFE. Repeat with ExtSel=0 -> ExtendOut=32'h0000FFFE.
- OutReady=0, push three entries back-to-back -> InReady=0 after the second. The third is held upstream. Raise OutReady -> the entries drain in order 1, 2, 3.
- Two entries buffered, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, and the flushed-cycle entry is absent.
- With `ALU_ISSUE_FWD_EN`: entry RtAddr=3 buffered with OutReady=0, FwdValid=1, FwdAddr=3, FwdData=32'hA5 -> ReadData2=32'hA5. With FwdAddr=0 -> no change.
- Assert Reset while count=2 and OutValid=1 -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and the issue-stage entry layout.
// ALU_ISSUE_FWD_EN adds the register addresses and A-source flag needed by forwarding.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_ANDN = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_XNOR = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] ext;
        logic              src_b;
        logic [2:0]        op;
`ifdef ALU_ISSUE_FWD_EN
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic              src_a;
`endif
    } entry_t;
endpackage

// File: rtl/alu_operand_ext.sv
// Push-path operand former: immediate sign/zero extension and the A-operand select.
module alu_operand_ext
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [4:0]        i_sa,
    input  logic [15:0]       i_imm,
    input  logic              i_ext_sel,
    input  logic              i_src_a,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ext
);
    assign o_ext = i_ext_sel ? {{(DATA_W-16){i_imm[15]}}, i_imm}
                             : {{(DATA_W-16){1'b0}}, i_imm};
    assign o_a   = i_src_a ? {{(DATA_W-5){1'b0}}, i_sa} : i_rs_data;
endmodule

// File: rtl/alu_issue_stage.sv
// ALU operand-issue stage: 2-entry skid FIFO between register read and the ALU.
// Define ALU_ISSUE_FWD_EN to enable write-back forwarding into incoming and buffered entries.
module alu_issue_stage
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2In,
    input  logic [REG_AW-1:0] RsAddr,
    input  logic [REG_AW-1:0] RtAddr,
    input  logic [4:0]        Sa,
    input  logic [15:0]       Immediate,
    input  logic              ExtSel,
    input  logic              ALUSrcA,
    input  logic              ALUSrcBIn,
    input  logic [2:0]        ALUOpIn,
    input  logic              FwdValid,
    input  logic [REG_AW-1:0] FwdAddr,
    input  logic [DATA_W-1:0] FwdData,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] ALUInputA,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] ExtendOut,
    output logic              ALUSrcB,
    output logic [2:0]        ALUOp
);
    entry_t      r_mem [2];
    logic        r_head, r_tail;
    logic [1:0]  r_count;

    logic              w_push, w_pop;
    logic [DATA_W-1:0] w_rs, w_rt, w_a, w_ext;
    entry_t            w_new, w_head;

`ifdef ALU_ISSUE_FWD_EN
    logic       w_fwd;
    logic [1:0] w_slot_vld;
    assign w_fwd = FwdValid && (FwdAddr != '0);
    assign w_rs  = (w_fwd && RsAddr == FwdAddr) ? FwdData : ReadData1;
    assign w_rt  = (w_fwd && RtAddr == FwdAddr) ? FwdData : ReadData2In;
    assign w_slot_vld[0] = (r_count == 2'd2) || (r_count == 2'd1 && !r_head);
    assign w_slot_vld[1] = (r_count == 2'd2) || (r_count == 2'd1 &&  r_head);
`else
    logic w_unused;
    assign w_rs     = ReadData1;
    assign w_rt     = ReadData2In;
    assign w_unused = ^{FwdValid, FwdAddr, FwdData, RsAddr, RtAddr};
`endif

    alu_operand_ext u_ext (
        .i_rs_data (w_rs),
        .i_sa      (Sa),
        .i_imm     (Immediate),
        .i_ext_sel (ExtSel),
        .i_src_a   (ALUSrcA),
        .o_a       (w_a),
        .o_ext     (w_ext)
    );

    always_comb begin
        w_new       = '0;
        w_new.a     = w_a;
        w_new.rt    = w_rt;
        w_new.ext   = w_ext;
        w_new.src_b = ALUSrcBIn;
        w_new.op    = ALUOpIn;
`ifdef ALU_ISSUE_FWD_EN
        w_new.rs_addr = RsAddr;
        w_new.rt_addr = RtAddr;
        w_new.src_a   = ALUSrcA;
`endif
    end

    // Ready is a pure function of occupancy so there is no OutReady->InReady path.
    assign InReady  = (r_count != 2'd2);
    assign OutValid = (r_count != 2'd0);
    assign w_push   = InValid && InReady;
    assign w_pop    = OutValid && OutReady;
    assign w_head   = r_mem[r_head];

    assign ALUInputA = OutValid ? w_head.a     : '0;
    assign ReadData2 = OutValid ? w_head.rt    : '0;
    assign ExtendOut = OutValid ? w_head.ext   : '0;
    assign ALUSrcB   = OutValid ? w_head.src_b : 1'b0;
    assign ALUOp     = OutValid ? w_head.op    : 3'b000;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        end else if (Flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
`ifdef ALU_ISSUE_FWD_EN
            // A write-back landing this cycle refreshes stale operands already buffered.
            for (int i = 0; i < 2; i++) begin
                if (w_fwd && w_slot_vld[i]) begin
                    if (!r_mem[i].src_a && r_mem[i].rs_addr == FwdAddr) r_mem[i].a  <= FwdData;
                    if (r_mem[i].rt_addr == FwdAddr)                    r_mem[i].rt <= FwdData;
                end
            end
`endif
            if (w_push) begin
                r_mem[r_tail] <= w_new;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios then random traffic.
module tb_alu_issue_stage;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        InValid, InReady;
    logic [31:0] ReadData1, ReadData2In, FwdData;
    logic [4:0]  RsAddr, RtAddr, Sa, FwdAddr;
    logic [15:0] Immediate;
    logic        ExtSel, ALUSrcA, ALUSrcBIn, FwdValid, Flush, OutValid, OutReady, ALUSrcB;
    logic [2:0]  ALUOpIn, ALUOp;
    logic [31:0] ALUInputA, ReadData2, ExtendOut;

    alu_issue_stage dut (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .ReadData1(ReadData1), .ReadData2In(ReadData2In), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .Sa(Sa), .Immediate(Immediate), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
        .ALUSrcBIn(ALUSrcBIn), .ALUOpIn(ALUOpIn), .FwdValid(FwdValid), .FwdAddr(FwdAddr),
        .FwdData(FwdData), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .ALUInputA(ALUInputA), .ReadData2(ReadData2), .ExtendOut(ExtendOut),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        inv;
        logic [31:0] rd1, rd2;
        logic [4:0]  rs, rt, sa;
        logic [15:0] imm;
        logic        extsel, srca, srcb;
        logic [2:0]  op;
        logic        fwdv;
        logic [4:0]  fwda;
        logic [31:0] fwdd;
        logic        flush, oready;
    } stim_t;

    typedef struct {
        logic [31:0] a, rt, ext;
        logic        srcb;
        logic [2:0]  op;
        logic [4:0]  rs_addr, rt_addr;
        logic        srca;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   run   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{inv:0, rd1:0, rd2:0, rs:0, rt:0, sa:0, imm:0, extsel:0, srca:0, srcb:0,
              op:0, fwdv:0, fwda:0, fwdd:0, flush:0, oready:1};
        return s;
    endfunction

    // Reference: what the ALU should see for an accepted instruction.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [31:0] rs_val, rt_val;
        rs_val = s.rd1;
        rt_val = s.rd2;
`ifdef ALU_ISSUE_FWD_EN
        if (s.fwdv && s.fwda != 0) begin
            if (s.rs == s.fwda) rs_val = s.fwdd;
            if (s.rt == s.fwda) rt_val = s.fwdd;
        end
`endif
        e.a       = s.srca ? 32'(s.sa) : rs_val;
        e.rt      = rt_val;
        e.ext     = (s.extsel && s.imm >= 16'h8000) ? (32'hFFFF_0000 + 32'(s.imm)) : 32'(s.imm);
        e.srcb    = s.srcb;
        e.op      = s.op;
        e.rs_addr = s.rs;
        e.rt_addr = s.rt;
        e.srca    = s.srca;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        InValid = s.inv; ReadData1 = s.rd1; ReadData2In = s.rd2; RsAddr = s.rs; RtAddr = s.rt;
        Sa = s.sa; Immediate = s.imm; ExtSel = s.extsel; ALUSrcA = s.srca; ALUSrcBIn = s.srcb;
        ALUOpIn = s.op; FwdValid = s.fwdv; FwdAddr = s.fwda; FwdData = s.fwdd;
        Flush = s.flush; OutReady = s.oready;
    endtask

    // Drive one cycle; update the expected contents after the monitor has looked at the head.
    task automatic step(input stim_t s);
        apply(s);
        @(negedge CLK); #1;
        if (s.flush) q.delete();
        else begin
`ifdef ALU_ISSUE_FWD_EN
            if (s.fwdv && s.fwda != 0)
                foreach (q[i]) begin
                    if (!q[i].srca && q[i].rs_addr == s.fwda) q[i].a = s.fwdd;
                    if (q[i].rt_addr == s.fwda) q[i].rt = s.fwdd;
                end
`endif
            if (s.inv && InReady) q.push_back(model(s));
        end
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (run && Reset) begin
            chk("in_ready", InReady, q.size() < 2);
            chk("out_valid", OutValid, q.size() != 0);
            if (q.size() != 0) begin
                chk("alu_a", ALUInputA, q[0].a);
                chk("rd2", ReadData2, q[0].rt);
                chk("ext", ExtendOut, q[0].ext);
                chk("srcb", ALUSrcB, q[0].srcb);
                chk("op", ALUOp, q[0].op);
                if (OutReady && !Flush) void'(q.pop_front());
            end else begin
                chk("idle_zero", {ALUInputA ^ ReadData2 ^ ExtendOut} | ALUInputA | ReadData2 | ExtendOut, 32'h0);
                chk("idle_ctl", {ALUSrcB, ALUOp}, 4'h0);
            end
        end
    end

    initial begin
        stim_t s;
        Reset = 1'b0;
        apply(idle());
        #3;
        chk("rst_out_valid", OutValid, 1'b0);
        chk("rst_in_ready", InReady, 1'b1);
        chk("rst_a", ALUInputA, 32'h0);
        chk("rst_ext", ExtendOut, 32'h0);
        @(posedge CLK); #1;
        Reset = 1'b1;
        run   = 1'b1;

        // single push with immediate drain
        s = idle(); s.inv = 1; s.rd1 = 5; s.op = 3'b000;
        step(s);
        chk("first_valid", OutValid, 1'b1);
        chk("first_a", ALUInputA, 32'd5);
        step(idle());
        chk("first_gone", OutValid, 1'b0);

        // shift-amount operand and both extension modes
        s = idle(); s.inv = 1; s.sa = 4; s.srca = 1; s.rd1 = 32'h1234; s.imm = 16'hFFFE; s.extsel = 1;
        s.oready = 0;
        step(s);
        chk("sa_a", ALUInputA, 32'd4);
        chk("sext", ExtendOut, 32'hFFFF_FFFE);
        s.extsel = 0; s.oready = 1; s.inv = 0;
        step(s);
        s.inv = 1; step(s);
        chk("zext", ExtendOut, 32'h0000_FFFE);
        step(idle());

        // back-pressure: third entry waits upstream, drain keeps order
        for (int i = 1; i <= 3; i++) begin
            s = idle(); s.inv = 1; s.rd1 = 32'(i); s.oready = 0;
            step(s);
        end
        chk("full_in_ready", InReady, 1'b0);
        s = idle(); s.inv = 1; s.rd1 = 3; s.oready = 1;
        step(s);
        chk("full_pop_in_ready", InReady, 1'b1);
        step(s);
        for (int i = 0; i < 3; i++) step(idle());

        // flush with a concurrent push
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.inv = 1; s.rd1 = 32'h10 + 32'(i); s.oready = 0;
            step(s);
        end
        s = idle(); s.inv = 1; s.rd1 = 32'hDEAD; s.flush = 1; s.oready = 0;
        step(s);
        chk("flush_valid", OutValid, 1'b0);
        chk("flush_ready", InReady, 1'b1);
        step(idle());

`ifdef ALU_ISSUE_FWD_EN
        s = idle(); s.inv = 1; s.rt = 3; s.rd2 = 32'h77; s.oready = 0;
        step(s);
        s = idle(); s.oready = 0; s.fwdv = 1; s.fwda = 3; s.fwdd = 32'hA5;
        step(s);
        chk("fwd_rt", ReadData2, 32'hA5);
        s.fwda = 0; s.fwdd = 32'h5A;
        step(s);
        chk("fwd_zero", ReadData2, 32'hA5);
        step(idle());
`endif

        // random traffic
        for (int n = 0; n < 400; n++) begin
            s.inv    = ($urandom_range(0, 9) < 7);
            s.rd1    = $urandom;
            s.rd2    = $urandom;
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.sa     = 5'($urandom);
            s.imm    = 16'($urandom);
            s.extsel = 1'($urandom);
            s.srca   = 1'($urandom);
            s.srcb   = 1'($urandom);
            s.op     = 3'($urandom);
            s.fwdv   = 1'($urandom);
            s.fwda   = 5'($urandom_range(0, 3));
            s.fwdd   = $urandom;
            s.flush  = ($urandom_range(0, 31) == 0);
            s.oready = ($urandom_range(0, 9) < 6);
            step(s);
        end

        // asynchronous reset while full
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.inv = 1; s.rd1 = 32'hC0 + 32'(i); s.imm = 16'h8001; s.extsel = 1; s.oready = 0;
            step(s);
        end
        chk("pre_rst_full", InReady, 1'b0);
        apply(idle());
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_valid", OutValid, 1'b0);
        chk("arst_ready", InReady, 1'b1);
        chk("arst_a", ALUInputA, 32'h0);
        chk("arst_ext", ExtendOut, 32'h0);
        q.delete();
        @(posedge CLK); #1;
        Reset = 1'b1;
        step(idle());
        step(idle());

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
